// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: two-flop synchronizer, shared sample-tick prescaler,
// and a per-bit saturating stability counter that flips db_out after STABLE_TICKS agreeing ticks.
module sw_debounce #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] change_pulse,
  output logic             tick
);

  localparam int            PW            = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_LAST      = 4'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [PW-1:0]    prescaler_reg;
  logic [PW-1:0]    prescaler_next;
  logic             tick_reg;
  logic             tick_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  // The debounce update happens on the same edge that raises tick, so tick
  // and any db_out/change_pulse update become visible together.
  assign tick_en = (prescaler_reg == PRESCALE_LAST);

  always_comb begin
    prescaler_next = prescaler_reg + PW'(1);
    if (tick_en) begin
      prescaler_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_reg <= '0;
      tick_reg      <= 1'b0;
    end else begin
      prescaler_reg <= prescaler_next;
      tick_reg      <= tick_en;
    end
  end

  assign tick = tick_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [3:0] cnt_reg;
      logic [3:0] cnt_next;
      logic       db_reg;
      logic       db_next;
      logic       pulse_reg;
      logic       pulse_next;

      always_comb begin
        cnt_next   = cnt_reg;
        db_next    = db_reg;
        pulse_next = 1'b0;
        if (tick_en) begin
          if (sync2_reg[gi] == db_reg) begin
            cnt_next = '0;
          end else if (cnt_reg >= CNT_LAST) begin
            // Saturating compare keeps the counter from ever wrapping.
            db_next    = sync2_reg[gi];
            cnt_next   = '0;
            pulse_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg   <= '0;
          db_reg    <= 1'b0;
          pulse_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          db_reg    <= db_next;
          pulse_reg <= pulse_next;
        end
      end

      assign db_out[gi]       = db_reg;
      assign change_pulse[gi] = pulse_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (TICK_DIV=4, STABLE_TICKS=3): expected flips are
// queued with their due edge and checked by a pulse monitor.
module tb_sw_debounce;
  localparam int WIDTH        = 18;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] raw_in = '0;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] change_pulse;
  logic             tick;

  sw_debounce #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS)) dut (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_in),
    .db_out(db_out), .change_pulse(change_pulse), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] db;
    int               edge_at;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;

  // Rising edges since the last reset release; sampled on the falling edge.
  always @(posedge clk) edge_no <= reset_n ? edge_no + 1 : 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] d, input int e);
    exp_t x;
    x.pulse = p;
    x.db = d;
    x.edge_at = e;
    sb_q.push_back(x);
    $display("queued: pulse=0x%05h db=0x%05h due edge %0d", p, d, e);
  endtask

  // Edge at which a level driven after edge h flips db_out: two sync stages,
  // first tick that sees it, then STABLE_TICKS-1 more ticks.
  function automatic int flip_edge(input int h);
    int e;
    e = h + 3;
    while (e % TICK_DIV != 0) e++;
    return e + TICK_DIV * (STABLE_TICKS - 1);
  endfunction

  task automatic wait_edge(input int target);
    int budget;
    budget = 1000;
    while (edge_no < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (edge_no < target) check("wait_timeout", edge_no, target);
  endtask

  task automatic settle(input string tag);
    int budget;
    budget = 200;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, sb_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && change_pulse !== '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", change_pulse, 0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_value", change_pulse, e.pulse);
        check("db_at_pulse", db_out, e.db);
        check("pulse_edge", edge_no, e.edge_at);
        $display("pulse seen: 0x%05h db=0x%05h at edge %0d", change_pulse, db_out, edge_no);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h;
    int e1;
    int pulses;

    // Reset with all inputs high, then tick cadence and full debounce.
    raw_in  = '1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_db", db_out, 0);
    check("rst_pulse", change_pulse, 0);
    check("rst_tick", tick, 0);
    push_exp(18'h3FFFF, 18'h3FFFF, 12);
    reset_n = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check("tick_cadence", tick, (k % TICK_DIV == 0) ? 1 : 0);
      if (k == 4 || k == 8) check("db_before_flip", db_out, 0);
    end
    check("pulse_one_cycle", change_pulse, 0);
    check("db_all_high", db_out, 18'h3FFFF);
    settle("sb_reset_high");

    // Bounce on bit 0, then hold high.
    reset_n = 1'b0;
    raw_in  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      raw_in[0] = ((c / 5) % 2 == 0);
      @(negedge clk);
    end
    check("db0_during_bounce", db_out[0], 0);
    raw_in[0] = 1'b1;
    h = edge_no;
    push_exp(18'h00001, 18'h00001, flip_edge(h));
    wait_edge(flip_edge(h) + 12);
    check("db0_stays_high", db_out, 18'h00001);
    settle("sb_bounce");

    // Bit 5 rises, then a single-cycle low glitch between ticks.
    raw_in[5] = 1'b1;
    h = edge_no;
    push_exp(18'h00020, 18'h00021, flip_edge(h));
    wait_edge(flip_edge(h) + 1);
    settle("sb_bit5");
    wait_edge(((edge_no / TICK_DIV) + 1) * TICK_DIV);
    raw_in[5] = 1'b0;
    @(negedge clk);
    raw_in[5] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (change_pulse !== '0) pulses++;
    end
    check("glitch_no_pulse", pulses, 0);
    check("glitch_db_held", db_out, 18'h00021);

    // Bit 17 steps while bit 3 bounces.
    raw_in[17] = 1'b1;
    h = edge_no;
    push_exp(18'h20000, 18'h20021, flip_edge(h));
    for (int c = 0; c < 40; c++) begin
      raw_in[3] = ((c / 5) % 2 == 0);
      @(negedge clk);
    end
    raw_in[3] = 1'b0;
    check("db17_set_db3_clear", db_out, 18'h20021);
    settle("sb_bit17");

    // Bits 1 and 2 step together.
    raw_in[2:1] = 2'b11;
    h = edge_no;
    push_exp(18'h00006, 18'h20027, flip_edge(h));
    wait_edge(flip_edge(h) + 1);
    settle("sb_simultaneous");
    check("db_after_simul", db_out, 18'h20027);

    // Reset asserted after two differing ticks on bit 9.
    raw_in[9] = 1'b1;
    h = edge_no;
    e1 = h + 3;
    while (e1 % TICK_DIV != 0) e1++;
    wait_edge(e1 + TICK_DIV);
    check("db9_before_reset", db_out, 18'h20027);
    reset_n = 1'b0;
    #1;
    check("async_rst_db", db_out, 0);
    check("async_rst_tick", tick, 0);
    check("async_rst_pulse", change_pulse, 0);
    repeat (2) @(negedge clk);
    push_exp(18'h20227, 18'h20227, 12);
    reset_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 4 || k == 8) check("db_after_release", db_out, 0);
    end
    settle("sb_mid_reset");
    check("db_final", db_out, 18'h20227);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 18, number of independent switch bits.
REQ-002 Parameter TICK_DIV, default 50000, clk cycles per sample tick; legal range 2..2^20.
REQ-003 Parameter STABLE_TICKS, default 8, consecutive differing tick-samples required before a bit flips; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 raw_in  input  WIDTH  raw switch levels, asynchronous to clk, may bounce.
REQ-007 db_out  output  WIDTH  debounced, registered switch levels; drives the switch PIO in_port.
REQ-008 change_pulse  output  WIDTH  registered; one-cycle strobe per bit when the matching db_out bit changes.
REQ-009 tick  output  1  registered sample-tick strobe, exposed for debug and verification.

Function
REQ-010 raw_in SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-011 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-012 tick SHALL be high for exactly one cycle when the prescaler equals TICK_DIV-1, giving exactly one tick per TICK_DIV cycles.
REQ-013 Each bit i SHALL own a 4-bit counter cnt[i].
REQ-014 On cycles with tick low, cnt[i] and db_out[i] SHALL hold and change_pulse[i] SHALL be 0.
REQ-015 On a tick with sync2[i]==db_out[i], cnt[i] SHALL clear to 0 and db_out[i] SHALL hold; this discards partial bounce counts.
REQ-016 On a tick with sync2[i]!=db_out[i] and cnt[i]<STABLE_TICKS-1, cnt[i] SHALL increment by 1.
REQ-017 On a tick with sync2[i]!=db_out[i] and cnt[i]==STABLE_TICKS-1:
  - db_out[i] SHALL take sync2[i] on that edge;
  - cnt[i] SHALL clear to 0;
  - change_pulse[i] SHALL be 1 on that same edge, for that one cycle only.
REQ-018 A bit SHALL therefore flip only after STABLE_TICKS consecutive ticks sample the new level; with STABLE_TICKS=1 it flips on the first differing tick.
REQ-019 cnt[i] SHALL never exceed STABLE_TICKS-1 and SHALL never wrap.
REQ-020 Bits SHALL be fully independent; simultaneous flips on several bits SHALL assert all matching change_pulse bits in the same cycle.
REQ-021 Pulses on raw_in shorter than the tick spacing that are not sampled on a tick SHALL have no effect.
REQ-022 Latency from a stable raw_in change to db_out SHALL lie between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV cycles.
REQ-023 db_out SHALL change only on tick edges; no combinational path SHALL exist from raw_in to any output.

Reset
REQ-024 While reset_n is low, the following SHALL be 0 immediately and asynchronously: sync1, sync2, prescaler, every cnt[i], db_out, change_pulse and tick.
REQ-025 After reset_n rises, the prescaler SHALL count from 0, giving the first tick on the TICK_DIV-th rising edge.
REQ-026 A reset asserted mid-count SHALL discard all partial counts; debounce restarts from zero after release.
REQ-027 Inputs that are high at reset SHALL appear on db_out only after the full debounce, with a change_pulse.

Verification (bench parameters: TICK_DIV=4, STABLE_TICKS=3, WIDTH=18)
REQ-028 tick cadence: release reset -> tick high on edges 4, 8, 12, ... after release, otherwise low.
REQ-029 Reset with inputs high: raw_in=0x3FFFF held through reset and release -> db_out=0 through ticks 1-2; on tick 3, db_out=0x3FFFF and change_pulse=0x3FFFF for one cycle, then change_pulse=0.
REQ-030 Bounce: raw_in[0] toggles every 5 cycles for 40 cycles, then holds 1 -> db_out[0] rises only after 3 consecutive ticks sample 1; exactly one change_pulse[0] is seen; db_out[0] never falls.
REQ-031 Glitch rejection: db_out[5]=1 and raw_in[5] pulsed low for 1 cycle between ticks -> db_out[5] stays 1 and change_pulse stays 0.
REQ-032 Independence and simultaneity:
  - raw_in[17] steps 0->1 while raw_in[3] bounces -> db_out[17] rises on schedule and db_out[3] is unaffected;
  - bits 1 and 2 step 0->1 in the same cycle -> change_pulse=0x00006 in a single cycle.
REQ-033 Reset mid-count: assert reset_n low after 2 differing ticks on bit 9 -> db_out=0; after release with raw_in[9] still 1, db_out[9] rises on the 3rd tick after release, not earlier.
